// File: rtl/pwm_cfg_pkg.sv
// Shared types and register map for the pwm configuration sequencer.
package pwm_cfg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    WPeriod = 2'd0,
    WDuty   = 2'd1,
    WCtrl   = 2'd2
  } widx_e;

  localparam logic [7:0] CtrlOfs   = 8'h00;
  localparam logic [7:0] PeriodOfs = 8'h04;
  localparam logic [7:0] DutyOfs   = 8'h08;
  localparam logic [7:0] ChStride  = 8'h10;

  function automatic logic [7:0] reg_ofs(widx_e idx);
    unique case (idx)
      WPeriod: return PeriodOfs;
      WDuty:   return DutyOfs;
      default: return CtrlOfs;
    endcase
  endfunction

endpackage

// File: rtl/pwm_cfg_timeout.sv
// Wait-state counter: cleared on clr_i, counts while en_i, flags the cycle
// whose increment would reach Limit.
module pwm_cfg_timeout #(
  parameter int unsigned Limit = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(Limit + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CntW'(Limit))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expired_o = en_i && (cnt_q == CntW'(Limit - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_cfg_sequencer.sv
// APB write master that programs one pwm channel per request:
// PERIOD, DUTY, CTRL when enabling, or a single CTRL=0 when disabling.
module pwm_cfg_sequencer
  import pwm_cfg_pkg::*;
#(
  parameter int unsigned                P_ADDR_BITWIDTH = 32,
  parameter int unsigned                P_DATA_BITWIDTH = 32,
  parameter logic [P_ADDR_BITWIDTH-1:0] P_BASE_ADDR     = '0,
  parameter int unsigned                P_TIMEOUT       = 255
) (
  input  logic                       PCLK,
  input  logic                       PRESETn,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [1:0]                 req_ch,
  input  logic                       req_en,
  input  logic [P_DATA_BITWIDTH-1:0] req_period,
  input  logic [P_DATA_BITWIDTH-1:0] req_duty,
  output logic [P_ADDR_BITWIDTH-1:0] PADDR,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [P_DATA_BITWIDTH-1:0] PWDATA,
  input  logic                       PREADY,
  input  logic                       PSLVERR,
  output logic                       done_valid,
  output logic                       done_err,
  output logic                       done_timeout,
  output logic                       done_clamped
);

  state_e                     state_q, state_d;
  widx_e                      idx_q, idx_d;
  logic [1:0]                 ch_q, ch_d;
  logic                       en_q, en_d;
  logic [P_DATA_BITWIDTH-1:0] period_q, period_d;
  logic [P_DATA_BITWIDTH-1:0] duty_q, duty_d;
  logic                       err_q, err_d;
  logic                       timeout_q, timeout_d;
  logic                       clamped_q, clamped_d;
  logic                       to_clr, to_en, to_expired;
  logic [P_ADDR_BITWIDTH-1:0] addr;
  logic [P_DATA_BITWIDTH-1:0] wdata;

  pwm_cfg_timeout #(
    .Limit(P_TIMEOUT)
  ) u_timeout (
    .clk_i    (PCLK),
    .rst_ni   (PRESETn),
    .clr_i    (to_clr),
    .en_i     (to_en),
    .expired_o(to_expired)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ch_d      = ch_q;
    en_d      = en_q;
    period_d  = period_q;
    duty_d    = duty_q;
    err_d     = err_q;
    timeout_d = timeout_q;
    clamped_d = clamped_q;
    to_clr    = 1'b0;
    to_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          ch_d      = req_ch;
          en_d      = req_en;
          period_d  = req_period;
          clamped_d = req_duty > req_period;
          duty_d    = (req_duty > req_period) ? req_period : req_duty;
          err_d     = 1'b0;
          timeout_d = 1'b0;
          idx_d     = req_en ? WPeriod : WCtrl;
          state_d   = StSetup;
        end
      end
      StSetup: begin
        to_clr  = 1'b1;
        state_d = StAccess;
      end
      StAccess: begin
        if (PREADY) begin
          if (PSLVERR) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else if (idx_q == WCtrl) begin
            state_d = StDone;
          end else begin
            idx_d   = (idx_q == WPeriod) ? WDuty : WCtrl;
            state_d = StSetup;
          end
        end else begin
          to_en = 1'b1;
          if (to_expired) begin
            timeout_d = 1'b1;
            state_d   = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    addr = P_BASE_ADDR + P_ADDR_BITWIDTH'(ch_q) * P_ADDR_BITWIDTH'(ChStride)
         + P_ADDR_BITWIDTH'(reg_ofs(idx_q));
    unique case (idx_q)
      WPeriod: wdata = period_q;
      WDuty:   wdata = duty_q;
      default: wdata = P_DATA_BITWIDTH'(en_q);
    endcase
  end

  // Bus outputs are zero whenever no transfer is in flight.
  always_comb begin
    PSEL         = (state_q == StSetup) || (state_q == StAccess);
    PENABLE      = (state_q == StAccess);
    PWRITE       = PSEL;
    PADDR        = PSEL ? addr : '0;
    PWDATA       = PSEL ? wdata : '0;
    req_ready    = (state_q == StIdle);
    done_valid   = (state_q == StDone);
    done_err     = done_valid && err_q;
    done_timeout = done_valid && timeout_q;
    done_clamped = done_valid && clamped_q;
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q   <= StIdle;
      idx_q     <= WPeriod;
      ch_q      <= '0;
      en_q      <= 1'b0;
      period_q  <= '0;
      duty_q    <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      clamped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ch_q      <= ch_d;
      en_q      <= en_d;
      period_q  <= period_d;
      duty_q    <= duty_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
      clamped_q <= clamped_d;
    end
  end

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Directed bench for pwm_cfg_sequencer with a small scriptable APB slave.
module tb_pwm_cfg_sequencer;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_ch;
  logic        req_en;
  logic [31:0] req_period;
  logic [31:0] req_duty;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        done_valid;
  logic        done_err;
  logic        done_timeout;
  logic        done_clamped;

  always #5 PCLK = ~PCLK;

  pwm_cfg_sequencer #(
    .P_ADDR_BITWIDTH(32),
    .P_DATA_BITWIDTH(32),
    .P_BASE_ADDR    (32'h0),
    .P_TIMEOUT      (8)
  ) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_ch      (req_ch),
    .req_en      (req_en),
    .req_period  (req_period),
    .req_duty    (req_duty),
    .PADDR       (PADDR),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PWDATA      (PWDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR),
    .done_valid  (done_valid),
    .done_err    (done_err),
    .done_timeout(done_timeout),
    .done_clamped(done_clamped)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Slave script and observation state.
  int          wait_tbl[3];
  int          err_at;
  bit          stall;
  int          wr_num, acc_cnt, acc_total, stab_err;
  logic [31:0] cap_addr, cap_data;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wr_at(input int i, input bit data);
    if (i >= wr_addr.size()) return 32'hDEAD_BEEF;
    return data ? wr_data[i] : wr_addr[i];
  endfunction

  always @(posedge PCLK) cyc <= cyc + 1;

  always @(negedge PCLK) begin
    if (PSEL && PENABLE) begin
      acc_total++;
      if (acc_cnt == 0) begin
        cap_addr = PADDR;
        cap_data = PWDATA;
      end else if (PADDR !== cap_addr || PWDATA !== cap_data) begin
        stab_err++;
      end
      if (!stall && acc_cnt >= ((wr_num < 3) ? wait_tbl[wr_num] : 0)) begin
        PREADY  = 1'b1;
        PSLVERR = (wr_num == err_at);
        wr_addr.push_back(PADDR);
        wr_data.push_back(PWDATA);
        wr_num++;
        acc_cnt = 0;
      end else begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        acc_cnt++;
      end
    end else begin
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
    end
  end

  task automatic clear_slave();
    wr_addr.delete();
    wr_data.delete();
    wr_num    = 0;
    acc_cnt   = 0;
    acc_total = 0;
    stab_err  = 0;
    wait_tbl  = '{0, 0, 0};
    err_at    = -1;
    stall     = 1'b0;
  endtask

  // Issues one request and waits (bounded) for done_valid; cycle 1 is the one after accept.
  task automatic do_req(input logic [1:0] ch, input logic en, input logic [31:0] per,
                        input logic [31:0] duty, output int dcyc, output logic [2:0] flags);
    int acc_cyc;
    bit seen;
    seen  = 1'b0;
    dcyc  = -1;
    flags = 3'b111;
    @(negedge PCLK);
    req_ch     = ch;
    req_en     = en;
    req_period = per;
    req_duty   = duty;
    req_valid  = 1'b1;
    @(negedge PCLK);
    acc_cyc   = cyc;
    req_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done_valid) begin
        dcyc  = cyc - acc_cyc + 1;
        flags = {done_err, done_timeout, done_clamped};
        seen  = 1'b1;
        break;
      end
      @(negedge PCLK);
    end
    check_eq("done_seen", 32'(seen), 32'd1);
    @(negedge PCLK);
    check_eq("done_one_cycle", 32'(done_valid), 32'd0);
    check_eq("ready_after_done", 32'(req_ready), 32'd1);
  endtask

  int          dcyc;
  logic [2:0]  flags;
  int          pulses;

  initial begin
    PRESETn    = 1'b0;
    req_valid  = 1'b0;
    req_ch     = '0;
    req_en     = 1'b0;
    req_period = '0;
    req_duty   = '0;
    PREADY     = 1'b0;
    PSLVERR    = 1'b0;
    clear_slave();
    repeat (2) @(negedge PCLK);
    check_eq("rst_psel", 32'(PSEL), 32'd0);
    check_eq("rst_penable", 32'(PENABLE), 32'd0);
    check_eq("rst_pwrite", 32'(PWRITE), 32'd0);
    check_eq("rst_paddr", PADDR, 32'd0);
    check_eq("rst_pwdata", PWDATA, 32'd0);
    check_eq("rst_done", 32'({done_valid, done_err, done_timeout, done_clamped}), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    PRESETn = 1'b1;

    // Enable ch2, zero-wait slave.
    clear_slave();
    do_req(2'd2, 1'b1, 32'd1000, 32'd250, dcyc, flags);
    check_eq("en_cycle", 32'(dcyc), 32'd7);
    check_eq("en_flags", 32'(flags), 32'd0);
    check_eq("en_nwr", 32'(wr_addr.size()), 32'd3);
    check_eq("en_a0", wr_at(0, 0), 32'h24);
    check_eq("en_d0", wr_at(0, 1), 32'd1000);
    check_eq("en_a1", wr_at(1, 0), 32'h28);
    check_eq("en_d1", wr_at(1, 1), 32'd250);
    check_eq("en_a2", wr_at(2, 0), 32'h20);
    check_eq("en_d2", wr_at(2, 1), 32'd1);

    // Disable ch1: single CTRL=0 write.
    clear_slave();
    do_req(2'd1, 1'b0, 32'd77, 32'd5, dcyc, flags);
    check_eq("dis_cycle", 32'(dcyc), 32'd3);
    check_eq("dis_nwr", 32'(wr_addr.size()), 32'd1);
    check_eq("dis_a0", wr_at(0, 0), 32'h10);
    check_eq("dis_d0", wr_at(0, 1), 32'd0);

    // Duty above period is clamped.
    clear_slave();
    do_req(2'd0, 1'b1, 32'd1000, 32'd1200, dcyc, flags);
    check_eq("clamp_flags", 32'(flags), 32'b001);
    check_eq("clamp_duty", wr_at(1, 1), 32'd1000);
    check_eq("clamp_a1", wr_at(1, 0), 32'h08);

    // Three wait states on the DUTY write.
    clear_slave();
    wait_tbl[1] = 3;
    do_req(2'd3, 1'b1, 32'd50, 32'd20, dcyc, flags);
    check_eq("wait_cycle", 32'(dcyc), 32'd10);
    check_eq("wait_flags", 32'(flags), 32'd0);
    check_eq("wait_nwr", 32'(wr_addr.size()), 32'd3);
    check_eq("wait_stable", 32'(stab_err), 32'd0);
    check_eq("wait_a1", wr_at(1, 0), 32'h38);
    check_eq("wait_d1", wr_at(1, 1), 32'd20);

    // Slave error on the PERIOD write aborts the sequence.
    clear_slave();
    err_at = 0;
    do_req(2'd0, 1'b1, 32'd10, 32'd3, dcyc, flags);
    check_eq("err_flags", 32'(flags), 32'b100);
    check_eq("err_nwr", 32'(wr_addr.size()), 32'd1);
    check_eq("err_cycle", 32'(dcyc), 32'd3);

    // PREADY held low: timeout after 8 ACCESS cycles.
    clear_slave();
    stall = 1'b1;
    do_req(2'd1, 1'b1, 32'd10, 32'd3, dcyc, flags);
    check_eq("to_flags", 32'(flags), 32'b010);
    check_eq("to_cycle", 32'(dcyc), 32'd10);
    check_eq("to_access", 32'(acc_total), 32'd8);
    check_eq("to_nwr", 32'(wr_addr.size()), 32'd0);

    // Reset during ACCESS of the DUTY write.
    clear_slave();
    wait_tbl[1] = 20;
    @(negedge PCLK);
    req_ch     = 2'd0;
    req_en     = 1'b1;
    req_period = 32'd40;
    req_duty   = 32'd10;
    req_valid  = 1'b1;
    @(negedge PCLK);
    req_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (PSEL && PENABLE && PADDR == 32'h08) break;
      @(negedge PCLK);
    end
    check_eq("rst_mid_reached", {PSEL, PENABLE, PADDR[29:0]}, {2'b11, 30'h08});
    PRESETn = 1'b0;
    @(negedge PCLK);
    check_eq("rst_mid_bus", 32'({PSEL, PENABLE}), 32'd0);
    check_eq("rst_mid_ready", 32'(req_ready), 32'd1);
    PRESETn = 1'b1;
    pulses  = 0;
    for (int i = 0; i < 5; i++) begin
      if (done_valid) pulses++;
      @(negedge PCLK);
    end
    check_eq("rst_mid_nodone", 32'(pulses), 32'd0);
    clear_slave();
    do_req(2'd2, 1'b1, 32'd1000, 32'd250, dcyc, flags);
    check_eq("post_rst_cycle", 32'(dcyc), 32'd7);
    check_eq("post_rst_nwr", 32'(wr_addr.size()), 32'd3);
    check_eq("post_rst_d2", wr_at(2, 1), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_cfg_sequencer.md
Name: pwm_cfg_sequencer

Overview:
APB master that configures the four-channel pwm APB slave from a simple valid/ready request interface. Each request updates one channel. Enabling a channel issues three ordered APB writes: PERIOD, then DUTY, then CTRL. Disabling a channel issues one write: CTRL=0. The block sits between a control source (CPU shim or host FSM) and the pwm slave, shares its clock, and reports completion, error and timeout.

Parameters:
P_ADDR_BITWIDTH, 32, APB address width
P_DATA_BITWIDTH, 32, APB data width; also the width of period and duty
P_BASE_ADDR, 32'h0, base address of the pwm slave
P_TIMEOUT, 255, maximum ACCESS cycles waiting for PREADY before abort (must be ≥1)

Ports:
PCLK  in  1  clock
PRESETn  in  1  reset, synchronous, active-low
req_valid  in  1  configuration request valid
req_ready  out  1  high only in IDLE
req_ch  in  2  target channel 0..3
req_en  in  1  1 = program and enable, 0 = disable only
req_period  in  P_DATA_BITWIDTH  period in PCLK cycles
req_duty  in  P_DATA_BITWIDTH  high time in PCLK cycles
PADDR  out  P_ADDR_BITWIDTH  APB address
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  always 1 while PSEL is high
PWDATA  out  P_DATA_BITWIDTH  APB write data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error
done_valid  out  1  one-cycle completion pulse
done_err  out  1  valid with done_valid: PSLVERR was seen
done_timeout  out  1  valid with done_valid: PREADY timeout occurred
done_clamped  out  1  valid with done_valid: duty was clamped to period

Behaviour:
- Reset (PRESETn=0 at a PCLK edge), all outputs at that edge:
  - PSEL, PENABLE, PWRITE, done_* = 0; PADDR, PWDATA = 0; req_ready = 1; FSM = IDLE.
  - Applies mid-transfer: PSEL drops on the same edge.
- Register map, fixed:
  - Channel base = P_BASE_ADDR + req_ch*0x10.
  - CTRL at +0x0 (bit0 = enable, other bits 0), PERIOD at +0x4, DUTY at +0x8.
- Accept: on an edge where req_valid & req_ready, latch ch, en, period and the effective duty.
  - Effective duty = min(duty, period); done_clamped is set when duty > period.
  - period=0 is legal and is written unchanged.
- FSM states: IDLE, SETUP, ACCESS, DONE.
  - Write index: 0 = PERIOD, 1 = DUTY, 2 = CTRL.
  - Start index is 0 if en=1, else 2.
- IDLE: on accept go to SETUP.
- SETUP (one cycle): PSEL=1, PENABLE=0, PWRITE=1; PADDR and PWDATA hold their final values. Next state is ACCESS.
- ACCESS: PSEL=1, PENABLE=1; PADDR and PWDATA held stable.
  - PREADY=1 & PSLVERR=1: set err; go to DONE, skipping remaining writes.
  - PREADY=1 & PSLVERR=0: if index=2 go to DONE, else increment index and go to SETUP.
  - PREADY=0: increment the wait counter. When it reaches P_TIMEOUT, set timeout, drop PSEL/PENABLE, go to DONE.
  - The wait counter clears on every SETUP entry.
- DONE (one cycle): PSEL=0, done_valid=1, flags presented; next state is IDLE.
  - Flags are cleared on the next accept.
- Latency with zero-wait slave, accept at edge 0:
  - en=1: SETUP/ACCESS pairs at cycles 1-2, 3-4, 5-6; done_valid at cycle 7; req_ready=1 at cycle 8.
  - en=0: single write at cycles 1-2; done_valid at cycle 3.
- PSEL never drops between SETUP and ACCESS of the same write. PSEL is low for at least the DONE cycle between requests.
- req_* are ignored outside IDLE; the requester must hold them until accepted.
- PRDATA is not consumed; the block issues no reads.

Decomposition:
- Package pwm_cfg_pkg holds:
  - state enum (IDLE, SETUP, ACCESS, DONE)
  - register offsets CTRL_OFS=0x0, PERIOD_OFS=0x4, DUTY_OFS=0x8
  - CH_STRIDE=0x10
  - write-index enum (W_PERIOD, W_DUTY, W_CTRL)
- Sub-module pwm_cfg_timeout: loadable wait counter with clear/enable and an expired flag. All other logic stays in pwm_cfg_sequencer.

Test Plan:
- ch=2, en=1, period=1000, duty=250, zero-wait slave -> writes 0x24=1000, 0x28=250, 0x20=1; done_valid at cycle 7 with all flags 0; pwm_out2 high 250 of every 1000 cycles.
- en=0, ch=1 -> single write 0x10=0; done_valid at cycle 3; pwm_out1 held low.
- duty=1200, period=1000 -> DUTY write carries 1000; done_clamped=1.
- Slave inserts 3 wait states on the DUTY write -> PADDR/PWDATA stable throughout, no extra writes, done at cycle 10. Then PSLVERR on the PERIOD write -> DUTY and CTRL are not issued; done_err=1.
- PREADY held low, P_TIMEOUT=8 -> PSEL drops after 8 ACCESS cycles; done_timeout=1; req_ready=1 on the following cycle.
- PRESETn=0 during ACCESS of the DUTY write -> PSEL/PENABLE are 0 at that edge, FSM is in IDLE, no done_valid pulse; the next request completes normally.
